mul_div_unit: RTL

- Multi-cycle multiply/divide unit in the EX stage, alongside the arithmetic ALU, sharing its A/B operand buses.
- Executes MULT, MULTU, DIV and DIVU iteratively at one bit per cycle.
- Holds the architectural HI/LO registers that feed MFHI/MFLO.
- Drives busy so the hazard unit stalls the pipeline while an operation is in flight.

---
 rtl/mul_div_unit_pkg.sv | 19 +
 rtl/mul_div_unit_negate.sv | 12 +
 rtl/mul_div_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Op encodings, FSM states and the default operand width.
package mul_div_unit_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    CALC = 2'd2,
    FIX  = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mul_div_unit_negate.sv
// Conditional two's-complement negation of a W-bit value.
module mul_div_unit_negate #(
  parameter int unsigned W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] x,
  output logic [W-1:0] y_c
);

  assign y_c = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit holding the HI/LO registers.
// One bit per cycle on unsigned magnitudes; signs are restored in FIX.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned DW = 2 * WIDTH;

  mdu_state_e       state, state_next;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             sa, sb;
  logic [DW-1:0]    acc;
  logic [CNT_W-1:0] cnt;

  logic             is_mul, is_signed, last_iter;
  logic [WIDTH-1:0] abs_a_c, abs_b_c, quo_c, rem_c;
  logic [DW-1:0]    prod_c;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic             div_ok;
  logic [WIDTH-1:0] div_rem;

  assign is_mul    = (op_q == MDU_MULT) || (op_q == MDU_MULTU);
  assign is_signed = (op_q == MDU_MULT) || (op_q == MDU_DIV);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // Magnitudes for signed ops; 0x80000000 stays 0x80000000 as an unsigned value.
  mul_div_unit_negate #(.W(WIDTH)) u_abs_a (
    .neg (is_signed & a_q[WIDTH-1]),
    .x   (a_q),
    .y_c (abs_a_c)
  );

  mul_div_unit_negate #(.W(WIDTH)) u_abs_b (
    .neg (is_signed & b_q[WIDTH-1]),
    .x   (b_q),
    .y_c (abs_b_c)
  );

  // Sign correction of the final result; sa/sb are zero for unsigned ops.
  mul_div_unit_negate #(.W(DW)) u_fix_prod (
    .neg (sa ^ sb),
    .x   (acc),
    .y_c (prod_c)
  );

  mul_div_unit_negate #(.W(WIDTH)) u_fix_quo (
    .neg (sa ^ sb),
    .x   (acc[WIDTH-1:0]),
    .y_c (quo_c)
  );

  mul_div_unit_negate #(.W(WIDTH)) u_fix_rem (
    .neg (sa),
    .x   (acc[DW-1:WIDTH]),
    .y_c (rem_c)
  );

  // One iteration of shift-add multiply and restoring divide.
  always_comb begin
    mul_sum   = {1'b0, acc[DW-1:WIDTH]} + (mag_a[0] ? {1'b0, mag_b} : {(WIDTH+1){1'b0}});
    div_shift = {acc[DW-1:WIDTH], mag_a[WIDTH-1]};
    div_ok    = (div_shift >= {1'b0, mag_b});
    div_rem   = div_ok ? WIDTH'(div_shift - {1'b0, mag_b}) : div_shift[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = PREP;
      PREP:    state_next = CALC;
      CALC:    if (last_iter) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      mag_a <= '0;
      mag_b <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      busy <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            a_q  <= A;
            b_q  <= B;
          end else begin
            if (mthi) hi <= A;
            if (mtlo) lo <= A;
          end
        end
        PREP: begin
          mag_a <= abs_a_c;
          mag_b <= abs_b_c;
          sa    <= is_signed & a_q[WIDTH-1];
          sb    <= is_signed & b_q[WIDTH-1];
          acc   <= '0;
          cnt   <= '0;
        end
        CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (is_mul) begin
            acc   <= {mul_sum, acc[WIDTH-1:1]};
            mag_a <= mag_a >> 1;
          end else begin
            acc   <= {div_rem, acc[WIDTH-2:0], div_ok};
            mag_a <= mag_a << 1;
          end
        end
        FIX: begin
          done <= 1'b1;
          if (is_mul) begin
            {hi, lo} <= prod_c;
          end else if (b_q == '0) begin
            // Divide by zero returns all-ones quotient and the untouched dividend.
            lo <= '1;
            hi <= a_q;
          end else begin
            lo <= quo_c;
            hi <= rem_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
